// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared types and constants for the pipeline sequencing controller
// Revision : 1.0
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam logic [4:0]  REG_X0    = 5'd0;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones instead of wrapping
// Revision : 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Stage enables/flushes for load-use, mispredict and dmem-wait hazards
// Revision : 1.0
// ============================================================================
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_mispredict,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_flush,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int              WC_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            memstall, loaduse, freeze, evaluate, halt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        memstall = mem_req & ~dmem_ready;
        loaduse  = ex_mem_read && (ex_rd != REG_X0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze     = 1'b0;
        evaluate   = 1'b0;
        halt       = 1'b0;

        if (rst) begin
            halt = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (memstall) begin
                        freeze     = 1'b1;
                        state_d    = MEM_WAIT;
                        wait_cnt_d = WC_W'(1);
                    end else begin
                        evaluate = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // A held mispredict in EX is only acted upon once memory releases the pipe.
                    if (dmem_ready) begin
                        evaluate = 1'b1;
                        state_d  = RUN;
                    end else begin
                        freeze = 1'b1;
                        if (wait_cnt_q == WC_LAST) begin
                            state_d = ERROR;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WC_W'(1);
                        end
                    end
                end
                default: halt = 1'b1;
            endcase
        end

        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        mem_wb_flush = 1'b0;

        if (halt) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (freeze) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (evaluate && ex_mispredict) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (evaluate && loaduse) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    assign mem_timeout_err = (state_q == ERROR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (~rst & ~pc_en),
        .count_o (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (~rst & if_id_flush),
        .count_o (flush_events)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed plus randomized check of the hazard controller against a reference model
// Revision : 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int TMO   = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, ex_mem_read, ex_mispredict, mem_req, dmem_ready;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
    logic mem_timeout_err;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 = flowing, 1 = waiting on memory, 2 = dead until reset
    int m_mode, m_waits, m_sc, m_fc;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mispredict(ex_mispredict),
        .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_flush(mem_wb_flush), .mem_timeout_err(mem_timeout_err),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_mispredict = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Compares every output with the model for the current inputs, then advances one clock.
    task automatic tick();
        bit ms, lu, frz;
        int e_pc, e_ifen, e_iff, e_iden, e_idf, e_exen, e_wbf;
        #2;
        ms  = mem_req && !dmem_ready;
        lu  = ex_mem_read && (ex_rd != 0) &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        frz = (m_mode == 0 && ms) || (m_mode == 1 && !dmem_ready);
        e_pc = 1; e_ifen = 1; e_iden = 1; e_exen = 1; e_iff = 0; e_idf = 0; e_wbf = 0;
        if (rst || m_mode == 2) begin
            e_pc = 0; e_ifen = 0; e_iden = 0; e_exen = 0;
        end else if (frz) begin
            e_pc = 0; e_ifen = 0; e_iden = 0; e_exen = 0; e_wbf = 1;
        end else if (ex_mispredict) begin
            e_iff = 1; e_idf = 1;
        end else if (lu) begin
            e_pc = 0; e_ifen = 0; e_idf = 1;
        end
        check_value("pc_en",        32'(pc_en),        32'(e_pc));
        check_value("if_id_en",     32'(if_id_en),     32'(e_ifen));
        check_value("if_id_flush",  32'(if_id_flush),  32'(e_iff));
        check_value("id_ex_en",     32'(id_ex_en),     32'(e_iden));
        check_value("id_ex_flush",  32'(id_ex_flush),  32'(e_idf));
        check_value("ex_mem_en",    32'(ex_mem_en),    32'(e_exen));
        check_value("mem_wb_flush", 32'(mem_wb_flush), 32'(e_wbf));
        check_value("timeout_err",  32'(mem_timeout_err), 32'(m_mode == 2));
        check_value("stall_cycles", 32'(stall_cycles), 32'(m_sc));
        check_value("flush_events", 32'(flush_events), 32'(m_fc));
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_waits = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (e_pc == 0)  m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
            if (e_iff == 1) m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
            if (m_mode == 0 && ms) begin
                m_mode = 1; m_waits = 1;
            end else if (m_mode == 1) begin
                if (dmem_ready)                m_mode = 0;
                else if (m_waits == TMO - 1)   m_mode = 2;
                else                           m_waits++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_mode = 0; m_waits = 0; m_sc = 0; m_fc = 0;
        do_reset();

        // Load-use on rs1 = x5
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_use_rs1 = 1'b1; id_rs1 = 5'd5;
        tick();
        check_value("loaduse_stall_cnt", 32'(stall_cycles), 32'd1);
        // Same pattern targeting x0 never stalls
        ex_rd = 5'd0; id_rs1 = 5'd0;
        tick();
        check_value("x0_no_stall_cnt", 32'(stall_cycles), 32'd1);

        // Mispredict redirect
        set_idle();
        ex_mispredict = 1'b1;
        tick();
        check_value("mispredict_flush_cnt", 32'(flush_events), 32'd1);

        // Memory wait with a mispredict pending: flush deferred to the ready cycle
        do_reset();
        mem_req = 1'b1; ex_mispredict = 1'b1; dmem_ready = 1'b0;
        repeat (3) tick();
        dmem_ready = 1'b1;
        tick();
        check_value("memwait_stall_cnt", 32'(stall_cycles), 32'd3);
        check_value("memwait_flush_cnt", 32'(flush_events), 32'd1);

        // Watchdog timeout, sticky until reset
        do_reset();
        mem_req = 1'b1; dmem_ready = 1'b0;
        repeat (TMO) tick();
        check_value("timeout_set", 32'(mem_timeout_err), 32'd1);
        repeat (3) tick();
        check_value("timeout_sticky", 32'(mem_timeout_err), 32'd1);
        do_reset();
        check_value("timeout_cleared", 32'(mem_timeout_err), 32'd0);

        // Stall counter saturation, then reset in the middle of a memory wait
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_use_rs2 = 1'b1; id_rs2 = 5'd7;
        repeat (20) tick();
        check_value("stall_saturated", 32'(stall_cycles), 32'(SAT));
        set_idle();
        mem_req = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_idle();
        check_value("rst_mid_wait_stall", 32'(stall_cycles), 32'd0);
        check_value("rst_mid_wait_flush", 32'(flush_events), 32'd0);
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 99) < 2);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            ex_rd         = 5'($urandom_range(0, 3));
            id_use_rs1    = 1'($urandom_range(0, 1));
            id_use_rs2    = 1'($urandom_range(0, 1));
            ex_mem_read   = 1'($urandom_range(0, 1));
            ex_mispredict = ($urandom_range(0, 9) < 2);
            mem_req       = ($urandom_range(0, 9) < 4);
            dmem_ready    = ($urandom_range(0, 9) < 6);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
